// File: rtl/instr_prefetch_unit.sv
// rtl/instr_prefetch_unit.sv - sequential instruction prefetcher with redirect flush and credit-checked FIFO
module instr_prefetch_unit #(
    parameter int D_WIDTH  = 32,
    parameter int A_WIDTH  = 4,
    parameter int DEPTH    = 4,
    parameter int PROG_LEN = 9
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     Start,
    input  logic                     Redirect,
    input  logic [A_WIDTH-1:0]       Redirect_PC,
    output logic [A_WIDTH-1:0]       Mem_Addr,
    output logic                     Mem_En,
    output logic                     Mem_RW,
    input  logic [D_WIDTH-1:0]       Mem_Data,
    output logic [D_WIDTH-1:0]       Instr,
    output logic [A_WIDTH-1:0]       Instr_PC,
    output logic                     Instr_Valid,
    input  logic                     Instr_Ready,
    output logic [$clog2(DEPTH):0]   Fifo_Count,
    output logic                     Prog_End
);

    localparam int P_WIDTH = $clog2(DEPTH);
    localparam int C_WIDTH = P_WIDTH + 1;
    localparam logic [A_WIDTH:0]   LIMIT   = (A_WIDTH+1)'(PROG_LEN);
    localparam logic [C_WIDTH-1:0] DEPTH_C = C_WIDTH'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_END
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [A_WIDTH-1:0]   fetch_pc;
    logic [A_WIDTH-1:0]   resp_pc;
    logic                 inflight;
    logic                 kill;
    logic [P_WIDTH-1:0]   rd_ptr;
    logic [P_WIDTH-1:0]   wr_ptr;
    logic [C_WIDTH-1:0]   count;
    logic [C_WIDTH-1:0]   occupancy;
    logic [D_WIDTH-1:0]   last_instr;
    logic [A_WIDTH-1:0]   last_pc;
    logic                 prog_end_q;
    logic [D_WIDTH-1:0]   data_mem [DEPTH];
    logic [A_WIDTH-1:0]   pc_mem   [DEPTH];

    logic redirect_go;
    logic pc_done;
    logic redirect_done;
    logic issue;
    logic live_inflight;
    logic push;
    logic pop;

    assign redirect_go   = Redirect && (state != S_IDLE);
    assign pc_done       = {1'b0, fetch_pc} >= LIMIT;
    assign redirect_done = {1'b0, Redirect_PC} >= LIMIT;
    // In-flight requests hold a credit so a returning response always finds a slot.
    assign occupancy     = count + C_WIDTH'(inflight);
    assign issue         = (state == S_RUN) && !pc_done && (occupancy < DEPTH_C);
    // A killed response belongs to the pre-redirect stream and no longer counts as outstanding.
    assign live_inflight = inflight && !kill;
    assign push          = live_inflight;
    assign pop           = Instr_Valid && Instr_Ready;

    assign Mem_En      = issue;
    assign Mem_Addr    = issue ? fetch_pc : '0;
    assign Mem_RW      = 1'b0;
    assign Instr_Valid = (count != '0);
    assign Instr       = Instr_Valid ? data_mem[rd_ptr] : last_instr;
    assign Instr_PC    = Instr_Valid ? pc_mem[rd_ptr]   : last_pc;
    assign Fifo_Count  = count;
    assign Prog_End    = prog_end_q;

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (Start) state_next = S_RUN;
            S_RUN:   if (pc_done) state_next = S_DRAIN;
            S_DRAIN: if ((count == '0) && !live_inflight) state_next = S_END;
            S_END:   state_next = S_END;
            default: state_next = S_IDLE;
        endcase
        if (redirect_go) begin
            state_next = redirect_done ? S_DRAIN : S_RUN;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state      <= S_IDLE;
            fetch_pc   <= '0;
            resp_pc    <= '0;
            inflight   <= 1'b0;
            kill       <= 1'b0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            last_instr <= '0;
            last_pc    <= '0;
            prog_end_q <= 1'b0;
        end else begin
            state      <= state_next;
            prog_end_q <= (state_next == S_END);
            inflight   <= issue;
            kill       <= issue && redirect_go;
            resp_pc    <= fetch_pc;
            if (Instr_Valid) begin
                last_instr <= Instr;
                last_pc    <= Instr_PC;
            end
            if (redirect_go) begin
                fetch_pc <= Redirect_PC;
            end else if ((state == S_IDLE) && Start) begin
                fetch_pc <= '0;
            end else if (issue) begin
                fetch_pc <= fetch_pc + A_WIDTH'(1);
            end
            if (redirect_go) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + P_WIDTH'(1);
                if (pop)  rd_ptr <= rd_ptr + P_WIDTH'(1);
                count <= count + C_WIDTH'(push) - C_WIDTH'(pop);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst && push && !redirect_go) begin
            data_mem[wr_ptr] <= Mem_Data;
            pc_mem[wr_ptr]   <= resp_pc;
        end
    end

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// tb/tb_instr_prefetch_unit.sv - directed self-checking bench for instr_prefetch_unit
module tb_instr_prefetch_unit;

    logic        Clk;
    logic        Rst;
    logic        Start;
    logic        Redirect;
    logic [3:0]  Redirect_PC;
    logic [3:0]  Mem_Addr;
    logic        Mem_En;
    logic        Mem_RW;
    logic [31:0] Mem_Data;
    logic [31:0] Instr;
    logic [3:0]  Instr_PC;
    logic        Instr_Valid;
    logic        Instr_Ready;
    logic [2:0]  Fifo_Count;
    logic        Prog_End;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [3:0]  req_addr [$];
    int          req_cyc  [$];
    logic [3:0]  out_pc   [$];
    logic [31:0] out_data [$];
    int          out_cyc  [$];

    instr_prefetch_unit #(
        .D_WIDTH(32), .A_WIDTH(4), .DEPTH(4), .PROG_LEN(9)
    ) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .Redirect(Redirect),
        .Redirect_PC(Redirect_PC), .Mem_Addr(Mem_Addr), .Mem_En(Mem_En),
        .Mem_RW(Mem_RW), .Mem_Data(Mem_Data), .Instr(Instr), .Instr_PC(Instr_PC),
        .Instr_Valid(Instr_Valid), .Instr_Ready(Instr_Ready),
        .Fifo_Count(Fifo_Count), .Prog_End(Prog_End)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Instruction memory: word k is 32'h1000_0000 + k, one-cycle read latency.
    always @(posedge Clk) Mem_Data <= 32'h1000_0000 + {28'd0, Mem_Addr};

    always @(posedge Clk) begin
        if (!Rst) begin
            if (Mem_En) begin
                req_addr.push_back(Mem_Addr);
                req_cyc.push_back(cyc);
            end
            if (Instr_Valid && Instr_Ready) begin
                out_pc.push_back(Instr_PC);
                out_data.push_back(Instr);
                out_cyc.push_back(cyc);
            end
        end
        cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge Clk);
    endtask

    task automatic clear_logs();
        req_addr.delete(); req_cyc.delete();
        out_pc.delete(); out_data.delete(); out_cyc.delete();
    endtask

    task automatic do_reset();
        Rst = 1'b1; Start = 1'b0; Redirect = 1'b0;
        tick(); tick();
        Rst = 1'b0;
    endtask

    task automatic start_pulse();
        Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    task automatic wait_prog_end(input string tag, input int budget);
        for (int i = 0; i < budget && !Prog_End; i++) tick();
        check(tag, Prog_End, 1);
    endtask

    function automatic logic [3:0] opc(input int k);
        return (k < out_pc.size()) ? out_pc[k] : 4'hF;
    endfunction

    function automatic logic [31:0] odata(input int k);
        return (k < out_data.size()) ? out_data[k] : 32'hDEAD_BEEF;
    endfunction

    task automatic check_full_stream(input string tag);
        check({tag, "_out_n"}, out_pc.size(), 9);
        for (int k = 0; k < 9; k++) begin
            check($sformatf("%s_pc%0d", tag, k), opc(k), k);
            check($sformatf("%s_data%0d", tag, k), odata(k), 32'h1000_0000 + k);
        end
    endtask

    initial begin
        Rst = 1'b1; Start = 1'b1; Redirect = 1'b0; Redirect_PC = 4'd0; Instr_Ready = 1'b0;

        // Reset held two cycles with Start asserted
        tick(); tick();
        check("rst_mem_addr", Mem_Addr, 0);
        check("rst_mem_en", Mem_En, 0);
        check("rst_mem_rw", Mem_RW, 0);
        check("rst_instr", Instr, 0);
        check("rst_instr_pc", Instr_PC, 0);
        check("rst_valid", Instr_Valid, 0);
        check("rst_count", Fifo_Count, 0);
        check("rst_prog_end", Prog_End, 0);
        Rst = 1'b0; Start = 1'b0;
        tick(); tick();
        check("idle_no_req", Mem_En, 0);
        check("idle_req_log", req_addr.size(), 0);

        // Streaming with Instr_Ready held high
        Instr_Ready = 1'b1;
        clear_logs();
        start_pulse();
        wait_prog_end("stream_prog_end", 40);
        check("stream_req_n", req_addr.size(), 9);
        for (int k = 0; k < 9; k++) begin
            check($sformatf("stream_addr%0d", k), (k < req_addr.size()) ? req_addr[k] : 4'hF, k);
            check($sformatf("stream_req_gap%0d", k),
                  (k < req_cyc.size()) ? req_cyc[k] - req_cyc[0] : -1, k);
            check($sformatf("stream_out_gap%0d", k),
                  (k < out_cyc.size()) ? out_cyc[k] - out_cyc[0] : -1, k);
        end
        check("stream_first_latency",
              (out_cyc.size() > 0 && req_cyc.size() > 0) ? out_cyc[0] - req_cyc[0] : -1, 2);
        check_full_stream("stream");
        tick(); tick(); tick();
        check("stream_prog_end_sticky", Prog_End, 1);
        check("stream_end_no_req", Mem_En, 0);

        // Backpressure, then full FIFO with a one-cycle Ready pulse
        do_reset();
        Instr_Ready = 1'b0;
        clear_logs();
        start_pulse();
        for (int i = 0; i < 8; i++) tick();
        check("bp_req_n", req_addr.size(), 4);
        check("bp_req_last", (req_addr.size() == 4) ? req_addr[3] : 4'hF, 3);
        check("bp_count", Fifo_Count, 4);
        check("bp_mem_en", Mem_En, 0);
        check("bp_valid", Instr_Valid, 1);
        check("bp_pc", Instr_PC, 0);
        check("bp_instr", Instr, 32'h1000_0000);
        tick(); tick();
        check("bp_pc_stable", Instr_PC, 0);
        check("bp_instr_stable", Instr, 32'h1000_0000);
        Instr_Ready = 1'b1;
        tick();
        Instr_Ready = 1'b0;
        check("full_pop_count", Fifo_Count, 3);
        check("full_req_en", Mem_En, 1);
        check("full_req_addr", Mem_Addr, 4);
        check("full_head_pc", Instr_PC, 1);
        tick();
        check("full_wait_count", Fifo_Count, 3);
        check("full_wait_no_req", Mem_En, 0);
        tick();
        check("full_refill_count", Fifo_Count, 4);
        Instr_Ready = 1'b1;
        wait_prog_end("bp_prog_end", 60);
        check("bp_req_total", req_addr.size(), 9);
        check_full_stream("bp");

        // Redirect to 6 while address 2's response is in flight
        do_reset();
        Instr_Ready = 1'b1;
        clear_logs();
        start_pulse();
        for (int i = 0; i < 10 && !(Mem_En && Mem_Addr == 4'd2); i++) tick();
        check("redir_saw_addr2", Mem_En && Mem_Addr == 4'd2, 1);
        tick();
        Redirect = 1'b1; Redirect_PC = 4'd6;
        tick();
        Redirect = 1'b0;
        check("redir_flush_count", Fifo_Count, 0);
        check("redir_flush_valid", Instr_Valid, 0);
        check("redir_first_en", Mem_En, 1);
        check("redir_first_addr", Mem_Addr, 6);
        wait_prog_end("redir_prog_end", 40);
        check("redir_out_n", out_pc.size(), 5);
        check("redir_out0", opc(0), 0);
        check("redir_out1", opc(1), 1);
        check("redir_out2", opc(2), 6);
        check("redir_out3", opc(3), 7);
        check("redir_out4", opc(4), 8);
        check("redir_data6", odata(2), 32'h1000_0006);

        // Redirect out of END clears Prog_End and restarts fetch
        clear_logs();
        Redirect = 1'b1; Redirect_PC = 4'd7;
        tick();
        Redirect = 1'b0;
        check("end_redir_prog_end", Prog_End, 0);
        check("end_redir_en", Mem_En, 1);
        check("end_redir_addr", Mem_Addr, 7);
        wait_prog_end("end_redir_prog_end2", 30);
        check("end_redir_out_n", out_pc.size(), 2);
        check("end_redir_out0", opc(0), 7);
        check("end_redir_out1", opc(1), 8);

        // Redirect to PROG_LEN during RUN
        do_reset();
        clear_logs();
        start_pulse();
        tick();
        Redirect = 1'b1; Redirect_PC = 4'd9;
        tick();
        Redirect = 1'b0;
        check("redir9_prog_end_r1", Prog_End, 0);
        check("redir9_no_req", Mem_En, 0);
        check("redir9_count", Fifo_Count, 0);
        tick();
        check("redir9_prog_end_r2", Prog_End, 1);
        check("redir9_out_n", out_pc.size(), 0);

        // Reset mid-operation with three words buffered
        do_reset();
        Instr_Ready = 1'b0;
        clear_logs();
        start_pulse();
        for (int i = 0; i < 10 && Fifo_Count != 3'd3; i++) tick();
        check("midrst_count3", Fifo_Count, 3);
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        check("midrst_count", Fifo_Count, 0);
        check("midrst_valid", Instr_Valid, 0);
        check("midrst_instr", Instr, 0);
        check("midrst_instr_pc", Instr_PC, 0);
        check("midrst_mem_en", Mem_En, 0);
        tick();
        check("midrst_no_capture", Fifo_Count, 0);
        check("midrst_no_capture_valid", Instr_Valid, 0);
        Instr_Ready = 1'b1;
        clear_logs();
        start_pulse();
        check("midrst_restart_addr", Mem_Addr, 0);
        check("midrst_restart_en", Mem_En, 1);
        wait_prog_end("midrst_prog_end", 40);
        check_full_stream("midrst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
